// File: rtl/nibble_add_seq.sv
// Multi-cycle N*W-bit adder stepping one N-bit slice per clock, LSB first.
// Optional SUB_EN macro adds a sub port selecting a-b (two's complement).
module nibble_add_seq #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic         ci,
`ifdef SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N*W-1:0] sum,
  output logic         co
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N*W-1:0]  a_q, a_d;
  logic [N*W-1:0]  b_q, b_d;
  logic            carry_q, carry_d;
  logic [N*W-1:0]  sum_q, sum_d;
  logic            co_q, co_d;

  logic [N-1:0]    a_sl;
  logic [N-1:0]    b_sl;
  logic [N:0]      slice;
  logic            can_acc;
  logic            last;

  // Active slice: pick operand slices by index, add with stored carry
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < W; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*N +: N];
        b_sl = b_q[i*N +: N];
      end
    end
    slice = {1'b0, a_sl} + {1'b0, b_sl} + {{N{1'b0}}, carry_q};
    last  = (idx_q == IW'(W - 1));
  end

  // Next-state: accept, slice stepping and result writeback
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    co_d    = co_q;
    can_acc = (state_q == IDLE) || (state_q == DONE);
    unique case (state_q)
      IDLE, DONE: begin
        if (can_acc && start) begin
          a_d     = a;
          idx_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
          state_d = RUN;
`ifdef SUB_EN
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : ci;
`else
          b_d     = b;
          carry_d = ci;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < W; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[i*N +: N] = slice[N-1:0];
          end
        end
        carry_d = slice[N];
        if (last) begin
          co_d    = slice[N];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: vector table plus corner sequences.
// Build with +define+SUB_EN to also exercise subtraction.
module tb_nibble_add_seq;

  localparam int N = 4;
  localparam int W = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [15:0]   a;
  logic [15:0]   b;
  logic          ci;
`ifdef SUB_EN
  logic          sub;
`endif
  logic          busy;
  logic          done;
  logic [15:0]   sum;
  logic          co;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] es;
    logic        eco;
  } vec_t;

  vec_t vecs[$];

  nibble_add_seq #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] va, input logic [15:0] vb,
                        input logic vci, input logic vsub);
    a  = va;
    b  = vb;
    ci = vci;
`ifdef SUB_EN
    sub = vsub;
`else
    if (vsub) $display("note: sub vector in add-only build");
`endif
  endtask

  // Full operation from IDLE: accept, W RUN cycles, DONE, back to IDLE
  task automatic run_op(input vec_t v, input string nm);
    set_in(v.a, v.b, v.ci, v.sub);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, ".acc_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, ".acc_sum"}, {15'd0, co, sum}, 32'd0);
    for (int i = 1; i < W; i++) begin
      step();
      chk({nm, ".run_busy"}, {30'd0, busy, done}, 32'd2);
    end
    step();
    chk({nm, ".done"}, {30'd0, busy, done}, 32'd1);
    chk({nm, ".sum"}, {16'd0, sum}, {16'd0, v.es});
    chk({nm, ".co"}, {31'd0, co}, {31'd0, v.eco});
    step();
    chk({nm, ".after"}, {30'd0, busy, done}, 32'd0);
    chk({nm, ".hold"}, {15'd0, co, sum}, {15'd0, v.eco, v.es});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    set_in(16'h0, 16'h0, 1'b0, 1'b0);

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1});
`ifdef SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1});
    vecs.push_back('{16'h0009, 16'h0009, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

    step();
    step();
    chk("reset.busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset.sum_co", {15'd0, co, sum}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle.busy_done", {30'd0, busy, done}, 32'd0);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // start on the second RUN cycle is ignored
    set_in(16'h00F0, 16'h0F0F, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    set_in(16'h0001, 16'h0001, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ign.done", {30'd0, busy, done}, 32'd1);
    chk("ign.res", {15'd0, co, sum}, 32'h0FFF);
    step();
    chk("ign.noextra1", {30'd0, busy, done}, 32'd0);
    step();
    chk("ign.noextra2", {30'd0, busy, done}, 32'd0);

    // start during DONE is accepted; next done W+1 cycles later
    set_in(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (W) step();
    chk("b2b.done1", {30'd0, busy, done}, 32'd1);
    chk("b2b.res1", {15'd0, co, sum}, 32'h1010);
    set_in(16'h8000, 16'h8000, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b.acc", {30'd0, busy, done}, 32'd2);
    chk("b2b.clr", {15'd0, co, sum}, 32'd0);
    repeat (W - 1) step();
    chk("b2b.run", {30'd0, busy, done}, 32'd2);
    step();
    chk("b2b.done2", {30'd0, busy, done}, 32'd1);
    chk("b2b.res2", {15'd0, co, sum}, 32'h10000);
    step();

    // reset during the third RUN cycle discards the operation
    set_in(16'h1234, 16'h1111, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst.busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst.sum_co", {15'd0, co, sum}, 32'd0);
    repeat (W) begin
      step();
      chk("rst.quiet", {30'd0, busy, done}, 32'd0);
    end
    run_op('{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0}, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequencer that performs an N·W-bit addition by stepping a single N-bit ripple-carry adder slice over W operand slices, one slice per clock, LSB slice first. The carry is registered between slices. The block sits between a requester (start/done handshake) and the shared narrow adder datapath. It trades W cycles of latency for an adder only N bits wide.

## Interface
Parameters:
- N, default 4: adder slice width in bits.
- W, default 4: number of slices; W ≥ 2; operand width is N·W (16 by default).

Ports (clock and reset first):
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only when the block can accept.
- a  input  N·W  operand A; captured on accept.
- b  input  N·W  operand B; captured on accept.
- ci  input  1  carry-in to slice 0; captured on accept.
- sub  input  1  subtract select; present only with SUB_EN.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; result valid.
- sum  output  N·W  result register.
- co  output  1  carry out of the top slice.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: slice counter idx runs 0..W-1, counter width ⌈log2 W⌉.
  - DONE: single-cycle result state.
- IDLE or DONE with start=1 → accept:
  - latch a, b into operand registers;
  - carry register ← ci;
  - idx ← 0;
  - sum ← 0, co ← 0;
  - state → RUN.
- RUN, each cycle:
  - compute slice result {c_out, s} = a[idx·N +: N] + b[idx·N +: N] + carry, with s N bits wide and c_out 1 bit;
  - write s into sum[idx·N +: N];
  - carry ← c_out.
- RUN, transitions:
  - idx < W-1: idx ← idx+1, stay in RUN.
  - idx = W-1: co ← c_out, state → DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted in that cycle.
- start while in RUN is ignored and not queued.
- sum and co hold their value from DONE until the next accept clears them.
- The result is arithmetically the exact N·W-bit sum a+b+ci; co is bit N·W of that sum.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, busy=0, done=0, sum=0, co=0, carry=0, idx=0.
  - Reset overrides everything, including in mid-RUN; the partial result is discarded.
- Accept at edge k:
  - busy=1 from after edge k through edge k+W-1.
  - At edge k+W: state=DONE, busy=0, done=1, sum and co final.
  - At edge k+W+1: done=0.
- Latency from accept to done is W cycles (4 by default).
- Throughput: a start during the DONE cycle is accepted. Back-to-back operations therefore take W+1 cycles each. done and the new busy overlap nothing: done=1/busy=0, then done=0/busy=1.
- busy is a registered output (state==RUN); done is state==DONE. Neither output depends combinationally on the inputs.

## Configuration
- SUB_EN defined:
  - port sub exists and is captured on accept.
  - sub=1: operand B register ← ~b, carry register ← 1, ci ignored. The result is a−b mod 2^(N·W); co=1 means no borrow.
  - sub=0: normal addition.
- SUB_EN undefined: no sub port; the block always adds.

## Test plan
- Basic add: a=0x1234, b=0x4321, ci=0, start pulse → busy for 4 cycles, then done=1 with sum=0x5555, co=0; done clears the following cycle.
- Full carry ripple across slices: a=0xFFFF, b=0x0000, ci=1 → sum=0x0000, co=1. Also a=0xFFFF, b=0xFFFF, ci=1 → sum=0xFFFF, co=1.
- Ignored start and back-to-back requests:
  - Pulse start with a=0x0001, b=0x0001 on the second RUN cycle of an op computing 0x00F0+0x0F0F → result 0x0FFF, co=0, and no extra operation follows.
  - Assert start during DONE with a=0x8000, b=0x8000 → next done shows sum=0x0000, co=1 five cycles later.
- Reset mid-operation: drive rst_n=0 for one edge during the third RUN cycle → busy=0, done=0, sum=0, co=0 afterward. A subsequent start computing 0x0001+0x0002 completes normally with sum=0x0003.
- SUB_EN build:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, co=0.
  - a=0x1000, b=0x0001, sub=1, ci=1 → sum=0x0FFF, co=1 (ci ignored).
- Non-SUB_EN build: rerun the basic add and full-carry-ripple scenarios and confirm the sub port is absent.
